mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Memory bus controller between the CPU core's memory access port (MAB/MDB) and the memory slaves: peripheral space, RAM, ROM.
- Latches one CPU request, decodes the region, and rebases the address to a slave-relative offset, so RAM sees 0x0000-0x01FF.
- Drives exactly one slave write strobe per write, returns registered read data with an ack pulse, and flags vacant or illegal accesses.

Parameters:
- PER_U, 16'h0200, exclusive upper bound of peripheral space (0x0000..PER_U-1)
- RAM_L, 16'h0200, inclusive RAM lower bound
- RAM_U, 16'h0400, exclusive RAM upper bound
- ROM_L, 16'hC000, inclusive ROM lower bound (ROM runs to 0xFFFF)
- VACANT, 16'h3FFF, read data returned for faulted accesses

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  access request, held until cpu_ack
- cpu_addr  in  16  byte address
- cpu_wdata  in  16  write data
- cpu_we  in  1  1=write, 0=read
- cpu_bw  in  1  1=byte access, 0=word access
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  16  read data, valid while cpu_ack=1, held until the next ack
- cpu_fault  out  1  valid with cpu_ack; access was vacant or illegal
- ram_addr  out  16  RAM offset (addr - RAM_L)
- ram_Din  out  16  RAM write data
- ram_RW  out  1  RAM write strobe
- BW  out  1  byte/word select to RAM and peripherals
- ram_out  in  16  RAM combinational read data
- rom_addr  out  16  ROM offset (addr - ROM_L)
- rom_out  in  16  ROM combinational read data
- per_addr  out  16  peripheral address
- per_Din  out  16  peripheral write data
- per_we  out  1  peripheral write strobe
- per_out  in  16  peripheral read data

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - cpu_ack=0, cpu_fault=0, cpu_rdata=0.
  - ram_RW=0, per_we=0, BW=0.
  - All address and data outputs are 0.
  - Reset asserted mid-access aborts it: no strobe, no ack.
- FSM states: IDLE, ACCESS, (WAIT), DONE.
- IDLE: when cpu_req=1, register addr/wdata/we/bw and the decoded region, then go to ACCESS.
  - Word accesses force addr[0]=0.
- Region decode (registered):
  - addr < PER_U: PER
  - RAM_L <= addr < RAM_U: RAM
  - addr >= ROM_L: ROM
  - anything else: VAC
  - A write to ROM: ILL.
- ACCESS, one cycle:
  - Drive the selected slave's address and data.
  - Assert that slave's write strobe (ram_RW or per_we) for exactly this cycle when we=1.
  - Capture read data at the end of the cycle.
  - Go to DONE (or WAIT if ROM and feature enabled).
- Byte read: cpu_rdata = {8'h00, slave_out[7:0]}.
- Byte write: data bus = {8'h00, wdata[7:0]}, BW=1.
- VAC or ILL: no strobe, cpu_rdata=VACANT, cpu_fault=1.
- DONE: cpu_ack=1 for one cycle, then back to IDLE.
- Latency: request accepted at edge N, ack high during cycle N+2 (no wait states).
- cpu_req is only sampled in IDLE. A request still high in the IDLE cycle after an ack starts a new access; the CPU must drop req on ack for a single access.
- Slave outputs return to 0 in IDLE and DONE; strobes are never high outside ACCESS.
- Boundary addresses:
  - 0x01FF: PER
  - 0x0200: RAM, offset 0
  - 0x03FF byte: RAM, offset 0x1FF
  - 0x0400: VAC
  - 0xBFFF: VAC
  - 0xC000: ROM, offset 0

Optional Feature:
- MEM_BUS_ROM_WAIT_EN defined: ROM reads go ACCESS → WAIT → DONE, adding 1 cycle; rom_addr is held through WAIT and data is captured at the end of WAIT.
- Undefined: no WAIT state, and ROM latency equals RAM latency.

Decomposition:
- Shared package mem_map_pkg:
  - region enum {PER, RAM, ROM, VAC}
  - FSM state enum
  - default bound constants and VACANT
- One natural sub-module, mem_region_dec: combinational address → region and offset, reused by a future DMA master.

Test Plan:
- Word write 0xBEEF to 0x0210, then word read 0x0210 → ram_RW high exactly 1 cycle with ram_addr=0x0010, BW=0; read ack at N+2 with rdata=0xBEEF, fault=0.
- Byte write 0x5A to 0x0211 with cpu_wdata=0x125A → ram_Din=0x005A, BW=1, ram_addr=0x0011; byte read returns 0x005A.
- Word read 0x0401 → no strobes, fault=1, rdata=0x3FFF; word write to 0xC002 → fault=1, ram_RW=per_we=0.
- ROM read 0xC004 with rom_out=0x4031 → rom_addr=0x0004, rdata=0x4031; ack at N+2, or N+3 with MEM_BUS_ROM_WAIT_EN.
- rst_n pulsed low during ACCESS of a write → strobe drops immediately, no ack; first request after release completes normally.
- cpu_req held high through ack → second access starts in the IDLE cycle after ack; exactly two strobes for two accesses.

Source files
------------

// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - memory map regions, controller states and default bounds
package mem_map_pkg;

  typedef enum logic [1:0] {PER, RAM, ROM, VAC} region_e;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;

  localparam logic [15:0] DEF_PER_U  = 16'h0200;
  localparam logic [15:0] DEF_RAM_L  = 16'h0200;
  localparam logic [15:0] DEF_RAM_U  = 16'h0400;
  localparam logic [15:0] DEF_ROM_L  = 16'hC000;
  localparam logic [15:0] DEF_VACANT = 16'h3FFF;

  // Byte accesses only ever use the low lane; the high lane reads/writes as zero.
  function automatic logic [15:0] byte_lane(input logic [15:0] d, input logic bw);
    return bw ? {8'h00, d[7:0]} : d;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// rtl/mem_bus_ctrl_if.sv - CPU memory access port (MAB/MDB request/ack bundle)
interface mem_bus_ctrl_if;

  logic        req;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        we;
  logic        bw;
  logic        ack;
  logic [15:0] rdata;
  logic        fault;

  modport master (output req, addr, wdata, we, bw, input ack, rdata, fault);
  modport slave  (input req, addr, wdata, we, bw, output ack, rdata, fault);

endinterface

// File: rtl/mem_region_dec.sv
// rtl/mem_region_dec.sv - combinational address to region / slave-relative offset decode
module mem_region_dec
  import mem_map_pkg::*;
#(
  parameter logic [15:0] PER_U = DEF_PER_U,
  parameter logic [15:0] RAM_L = DEF_RAM_L,
  parameter logic [15:0] RAM_U = DEF_RAM_U,
  parameter logic [15:0] ROM_L = DEF_ROM_L
) (
  input  logic [15:0] addr,
  output region_e     region,
  output logic [15:0] offset
);

  always_comb begin
    region = VAC;
    offset = 16'h0000;
    if (addr < PER_U) begin
      region = PER;
      offset = addr;
    end else if (addr >= RAM_L && addr < RAM_U) begin
      region = RAM;
      offset = addr - RAM_L;
    end else if (addr >= ROM_L) begin
      region = ROM;
      offset = addr - ROM_L;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - CPU to PER/RAM/ROM bus controller; MEM_BUS_ROM_WAIT_EN adds a ROM read wait state
module mem_bus_ctrl
  import mem_map_pkg::*;
#(
  parameter logic [15:0] PER_U  = DEF_PER_U,
  parameter logic [15:0] RAM_L  = DEF_RAM_L,
  parameter logic [15:0] RAM_U  = DEF_RAM_U,
  parameter logic [15:0] ROM_L  = DEF_ROM_L,
  parameter logic [15:0] VACANT = DEF_VACANT
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_bus_ctrl_if.slave  cpu,
  output logic [15:0]    ram_addr,
  output logic [15:0]    ram_Din,
  output logic           ram_RW,
  output logic           BW,
  input  logic [15:0]    ram_out,
  output logic [15:0]    rom_addr,
  input  logic [15:0]    rom_out,
  output logic [15:0]    per_addr,
  output logic [15:0]    per_Din,
  output logic           per_we,
  input  logic [15:0]    per_out
);

  state_e      state, state_nx;
  region_e     dec_region, region_q;
  logic [15:0] addr_in, dec_off;
  logic [15:0] off_q, wdata_q, rdata_q, slave_rd;
  logic        we_q, bw_q, err_q, fault_q;
  logic        cap;

  assign addr_in = cpu.bw ? cpu.addr : {cpu.addr[15:1], 1'b0};

  mem_region_dec #(
    .PER_U (PER_U),
    .RAM_L (RAM_L),
    .RAM_U (RAM_U),
    .ROM_L (ROM_L)
  ) u_dec (
    .addr   (addr_in),
    .region (dec_region),
    .offset (dec_off)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cap      = 1'b0;
    case (state)
      IDLE:   if (cpu.req) state_nx = ACCESS;
      ACCESS: begin
        state_nx = DONE;
        cap      = 1'b1;
`ifdef MEM_BUS_ROM_WAIT_EN
        if (region_q == ROM && !we_q) begin
          state_nx = WAIT;
          cap      = 1'b0;
        end
`endif
      end
`ifdef MEM_BUS_ROM_WAIT_EN
      WAIT: begin
        state_nx = DONE;
        cap      = 1'b1;
      end
`endif
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latch: region and fault class are resolved here, so ACCESS only muxes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q    <= 16'h0000;
      wdata_q  <= 16'h0000;
      we_q     <= 1'b0;
      bw_q     <= 1'b0;
      region_q <= VAC;
      err_q    <= 1'b0;
    end else if (state == IDLE && cpu.req) begin
      off_q    <= dec_off;
      wdata_q  <= cpu.wdata;
      we_q     <= cpu.we;
      bw_q     <= cpu.bw;
      region_q <= dec_region;
      err_q    <= (dec_region == VAC) || (dec_region == ROM && cpu.we);
    end
  end

  always_comb begin
    case (region_q)
      PER:     slave_rd = per_out;
      RAM:     slave_rd = ram_out;
      ROM:     slave_rd = rom_out;
      default: slave_rd = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 16'h0000;
      fault_q <= 1'b0;
    end else if (cap) begin
      rdata_q <= err_q ? VACANT : byte_lane(slave_rd, bw_q);
      fault_q <= err_q;
    end
  end

  assign cpu.ack   = (state == DONE);
  assign cpu.rdata = rdata_q;
  assign cpu.fault = fault_q;

  // Slave side is purely a function of state, so an async reset drops strobes at once.
  always_comb begin
    ram_addr = 16'h0000;
    ram_Din  = 16'h0000;
    ram_RW   = 1'b0;
    rom_addr = 16'h0000;
    per_addr = 16'h0000;
    per_Din  = 16'h0000;
    per_we   = 1'b0;
    BW       = 1'b0;
    if (state == ACCESS && !err_q) begin
      BW = bw_q;
      case (region_q)
        RAM: begin
          ram_addr = off_q;
          ram_Din  = byte_lane(wdata_q, bw_q);
          ram_RW   = we_q;
        end
        PER: begin
          per_addr = off_q;
          per_Din  = byte_lane(wdata_q, bw_q);
          per_we   = we_q;
        end
        ROM:     rom_addr = off_q;
        default: ;
      endcase
    end
    if (state == WAIT) begin
      BW       = bw_q;
      rom_addr = off_q;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - directed vector bench for mem_bus_ctrl
module tb_mem_bus_ctrl;
  import mem_map_pkg::*;

  localparam logic [1:0] S_NONE = 2'd0, S_PER = 2'd1, S_RAM = 2'd2, S_ROM = 2'd3;
`ifdef MEM_BUS_ROM_WAIT_EN
  localparam int ROM_WAIT = 1;
`else
  localparam int ROM_WAIT = 0;
`endif
  localparam int NV = 18;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        bw;
    logic [1:0]  sel;
    logic [15:0] saddr;
    logic [15:0] din;
    logic [15:0] rdata;
    logic        fault;
    logic        chk_rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ram_addr, ram_Din, ram_out, rom_addr, rom_out, per_addr, per_Din, per_out;
  logic        ram_RW, BW, per_we;
  int          n_cmp = 0, n_err = 0;
  int          ram_strb = 0, per_strb = 0;
  logic [7:0]  ram_mem [0:511] = '{default: 8'h00};
  vec_t        vecs [NV];

  always #5 clk = ~clk;

  mem_bus_ctrl_if cpu_bus ();

  mem_bus_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu      (cpu_bus.slave),
    .ram_addr (ram_addr),
    .ram_Din  (ram_Din),
    .ram_RW   (ram_RW),
    .BW       (BW),
    .ram_out  (ram_out),
    .rom_addr (rom_addr),
    .rom_out  (rom_out),
    .per_addr (per_addr),
    .per_Din  (per_Din),
    .per_we   (per_we),
    .per_out  (per_out)
  );

  // Byte-addressed RAM model: byte reads present the addressed byte on the low lane.
  assign ram_out = BW ? {8'h00, ram_mem[ram_addr[8:0]]}
                      : {ram_mem[{ram_addr[8:1], 1'b1}], ram_mem[{ram_addr[8:1], 1'b0}]};
  assign rom_out = (rom_addr == 16'h0004) ? 16'h4031 : {rom_addr[7:0], 8'h77};
  assign per_out = per_addr ^ 16'h1234;

  always @(posedge clk) begin
    if (ram_RW) begin
      if (BW) ram_mem[ram_addr[8:0]] <= ram_Din[7:0];
      else begin
        ram_mem[{ram_addr[8:1], 1'b0}] <= ram_Din[7:0];
        ram_mem[{ram_addr[8:1], 1'b1}] <= ram_Din[15:8];
      end
    end
  end

  always @(negedge clk) begin
    if (ram_RW) ram_strb++;
    if (per_we) per_strb++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_access(input vec_t v, input string t);
    int rb, pb, lat, wt;
    rb = ram_strb;
    pb = per_strb;
    @(negedge clk);
    cpu_bus.req   = 1'b1;
    cpu_bus.addr  = v.addr;
    cpu_bus.wdata = v.wdata;
    cpu_bus.we    = v.we;
    cpu_bus.bw    = v.bw;
    @(negedge clk);
    chk({t, "_ram_RW"},   32'(ram_RW),   32'(v.we && v.sel == S_RAM));
    chk({t, "_per_we"},   32'(per_we),   32'(v.we && v.sel == S_PER));
    chk({t, "_ram_addr"}, 32'(ram_addr), 32'((v.sel == S_RAM) ? v.saddr : 16'h0000));
    chk({t, "_per_addr"}, 32'(per_addr), 32'((v.sel == S_PER) ? v.saddr : 16'h0000));
    chk({t, "_rom_addr"}, 32'(rom_addr), 32'((v.sel == S_ROM) ? v.saddr : 16'h0000));
    chk({t, "_BW"},       32'(BW),       32'((v.sel != S_NONE) ? v.bw : 1'b0));
    if (v.we && v.sel == S_RAM) chk({t, "_ram_Din"}, 32'(ram_Din), 32'(v.din));
    if (v.we && v.sel == S_PER) chk({t, "_per_Din"}, 32'(per_Din), 32'(v.din));
    chk({t, "_early_ack"}, 32'(cpu_bus.ack), 32'd0);
    lat = 0;
    while (lat < 4) begin
      @(negedge clk);
      lat++;
      if (cpu_bus.ack) break;
    end
    wt = (ROM_WAIT != 0 && v.sel == S_ROM && !v.we) ? 1 : 0;
    chk({t, "_ack_lat"}, 32'(lat), 32'(1 + wt));
    chk({t, "_fault"},   32'(cpu_bus.fault), 32'(v.fault));
    if (v.chk_rd) chk({t, "_rdata"}, 32'(cpu_bus.rdata), 32'(v.rdata));
    chk({t, "_ram_strb"}, 32'(ram_strb - rb), 32'((v.we && v.sel == S_RAM) ? 1 : 0));
    chk({t, "_per_strb"}, 32'(per_strb - pb), 32'((v.we && v.sel == S_PER) ? 1 : 0));
    cpu_bus.req = 1'b0;
    @(negedge clk);
    chk({t, "_ack_pulse"}, 32'(cpu_bus.ack), 32'd0);
    if (v.chk_rd) chk({t, "_rdata_hold"}, 32'(cpu_bus.rdata), 32'(v.rdata));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   acks, first_c, second_c, rb;

    //            addr      wdata     we    bw    sel     saddr     din       rdata     flt   chk
    vecs[0]  = '{16'h0210, 16'hBEEF, 1'b1, 1'b0, S_RAM,  16'h0010, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{16'h0210, 16'h0000, 1'b0, 1'b0, S_RAM,  16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b1};
    vecs[2]  = '{16'h0211, 16'h125A, 1'b1, 1'b1, S_RAM,  16'h0011, 16'h005A, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{16'h0211, 16'h0000, 1'b0, 1'b1, S_RAM,  16'h0011, 16'h0000, 16'h005A, 1'b0, 1'b1};
    vecs[4]  = '{16'h0211, 16'h0000, 1'b0, 1'b0, S_RAM,  16'h0010, 16'h0000, 16'h5AEF, 1'b0, 1'b1};
    vecs[5]  = '{16'h0401, 16'h0000, 1'b0, 1'b0, S_NONE, 16'h0000, 16'h0000, 16'h3FFF, 1'b1, 1'b1};
    vecs[6]  = '{16'hC002, 16'h1234, 1'b1, 1'b0, S_NONE, 16'h0000, 16'h0000, 16'h3FFF, 1'b1, 1'b1};
    vecs[7]  = '{16'hC004, 16'h0000, 1'b0, 1'b0, S_ROM,  16'h0004, 16'h0000, 16'h4031, 1'b0, 1'b1};
    vecs[8]  = '{16'hC000, 16'h0000, 1'b0, 1'b0, S_ROM,  16'h0000, 16'h0000, 16'h0077, 1'b0, 1'b1};
    vecs[9]  = '{16'h01FF, 16'h0000, 1'b0, 1'b1, S_PER,  16'h01FF, 16'h0000, 16'h00CB, 1'b0, 1'b1};
    vecs[10] = '{16'h0100, 16'hA55A, 1'b1, 1'b0, S_PER,  16'h0100, 16'hA55A, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{16'h03FF, 16'hFF77, 1'b1, 1'b1, S_RAM,  16'h01FF, 16'h0077, 16'h0000, 1'b0, 1'b0};
    vecs[12] = '{16'h03FF, 16'h0000, 1'b0, 1'b1, S_RAM,  16'h01FF, 16'h0000, 16'h0077, 1'b0, 1'b1};
    vecs[13] = '{16'h0400, 16'h0000, 1'b0, 1'b0, S_NONE, 16'h0000, 16'h0000, 16'h3FFF, 1'b1, 1'b1};
    vecs[14] = '{16'hBFFF, 16'h0000, 1'b0, 1'b0, S_NONE, 16'h0000, 16'h0000, 16'h3FFF, 1'b1, 1'b1};
    vecs[15] = '{16'hFFFF, 16'h00AA, 1'b1, 1'b1, S_NONE, 16'h0000, 16'h0000, 16'h3FFF, 1'b1, 1'b1};
    vecs[16] = '{16'h0200, 16'h0000, 1'b0, 1'b0, S_RAM,  16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[17] = '{16'h0000, 16'h0000, 1'b0, 1'b0, S_PER,  16'h0000, 16'h0000, 16'h1234, 1'b0, 1'b1};

    cpu_bus.req   = 1'b0;
    cpu_bus.addr  = 16'h0000;
    cpu_bus.wdata = 16'h0000;
    cpu_bus.we    = 1'b0;
    cpu_bus.bw    = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_ack",      32'(cpu_bus.ack),   32'd0);
    chk("rst_fault",    32'(cpu_bus.fault), 32'd0);
    chk("rst_rdata",    32'(cpu_bus.rdata), 32'd0);
    chk("rst_strobes",  32'({ram_RW, per_we, BW}), 32'd0);
    chk("rst_addrs",    32'(ram_addr | rom_addr | per_addr), 32'd0);
    chk("rst_data",     32'(ram_Din | per_Din), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) do_access(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a RAM write: strobe must vanish and nothing completes.
    @(negedge clk);
    cpu_bus.req   = 1'b1;
    cpu_bus.addr  = 16'h0220;
    cpu_bus.wdata = 16'h1111;
    cpu_bus.we    = 1'b1;
    cpu_bus.bw    = 1'b0;
    @(negedge clk);
    chk("abort_pre_strobe", 32'(ram_RW), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_strobe_drop", 32'(ram_RW), 32'd0);
    chk("abort_addr_drop",   32'(ram_addr), 32'd0);
    cpu_bus.req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_bus.ack) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    v = '{16'h0220, 16'h0000, 1'b0, 1'b0, S_RAM, 16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b1};
    do_access(v, "abort_rd_unwritten");
    v = '{16'h0220, 16'h1111, 1'b1, 1'b0, S_RAM, 16'h0020, 16'h1111, 16'h0000, 1'b0, 1'b0};
    do_access(v, "post_rst_wr");
    v = '{16'h0220, 16'h0000, 1'b0, 1'b0, S_RAM, 16'h0020, 16'h0000, 16'h1111, 1'b0, 1'b1};
    do_access(v, "post_rst_rd");

    // Request held through the ack: a second access follows, spaced DONE-IDLE-ACCESS-DONE.
    rb = ram_strb;
    first_c = 0;
    second_c = 0;
    acks = 0;
    @(negedge clk);
    cpu_bus.req   = 1'b1;
    cpu_bus.addr  = 16'h0230;
    cpu_bus.wdata = 16'h2222;
    cpu_bus.we    = 1'b1;
    cpu_bus.bw    = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (cpu_bus.ack) begin
        acks++;
        if (acks == 1) first_c = c;
        else begin
          second_c = c;
          cpu_bus.req = 1'b0;
          break;
        end
      end
    end
    cpu_bus.req = 1'b0;
    chk("held_acks",     32'(acks), 32'd2);
    chk("held_spacing",  32'(second_c - first_c), 32'd3);
    chk("held_strobes",  32'(ram_strb - rb), 32'd2);
    repeat (3) @(negedge clk);
    chk("held_no_third", 32'(ram_strb - rb), 32'd2);
    v = '{16'h0230, 16'h0000, 1'b0, 1'b0, S_RAM, 16'h0030, 16'h0000, 16'h2222, 1'b0, 1'b1};
    do_access(v, "held_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
